// File: rtl/opram_fetch_if.sv
// Opcode stream to the decoder plus the read-side pin bundle of the 256x8 opcode RAM.
// The fetch master drives the RAM pins and the opcode stream; the slave side is decoder + RAM.
interface opram_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_data;
    logic [AW-1:0] op_addr;

    logic          ram_ce;
    logic          ram_oce;
    logic          ram_wre;
    logic          ram_reset;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_dout;

    modport master (
        output op_valid, op_data, op_addr,
        output ram_ce, ram_oce, ram_wre, ram_reset, ram_ad,
        input  op_ready, ram_dout
    );

    modport slave (
        input  op_valid, op_data, op_addr,
        input  ram_ce, ram_oce, ram_wre, ram_reset, ram_ad,
        output op_ready, ram_dout
    );
endinterface

// File: rtl/opram_fetch.sv
// Opcode fetch master: walks a PC through the opcode RAM, captures read data one cycle
// after each issue and streams {addr, byte} to the decoder through a small output FIFO.
module opram_fetch #(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter int            FDEPTH   = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    opram_fetch_if.master bus
);
    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] FDEPTH_L = (CW+1)'(FDEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    pc_reg;
    logic [AW-1:0]    ret_addr_reg;
    logic             inflight_reg;
    logic [CW-1:0]    count_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [AW+DW-1:0] fifo_reg [FDEPTH];

    logic             pop_req;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CW:0]      level;
    logic [FDEPTH-1:0] wr_sel;

    // Occupancy the FIFO will reach once the pending return lands; uses the raw pop so the
    // issue decision never depends on jump_en (a jump suppresses issue anyway).
    assign pop_req = bus.op_valid & bus.op_ready;
    assign pop     = pop_req & ~jump_en;
    assign push    = inflight_reg & ~jump_en;
    assign level   = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, pop_req};

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run) state_next = RUN;
            end
            RUN: begin
                if (!run) state_next = IDLE;
                issue = ~jump_en & (level < FDEPTH_L);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            ret_addr_reg <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (jump_en) begin
                pc_reg       <= jump_addr;
                inflight_reg <= 1'b0;
                count_reg    <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
            end else begin
                inflight_reg <= issue;
                if (issue) begin
                    ret_addr_reg <= pc_reg;
                    pc_reg       <= pc_reg + AW'(1);
                end
                if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < FDEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Entries are cleared on reset so op_data/op_addr read as zero out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FDEPTH; i++) begin
            if (reset) begin
                fifo_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                fifo_reg[i] <= {ret_addr_reg, bus.ram_dout};
            end
        end
    end

    assign bus.op_valid  = (count_reg != '0);
    assign bus.op_addr   = fifo_reg[rd_ptr_reg][AW+DW-1:DW];
    assign bus.op_data   = fifo_reg[rd_ptr_reg][DW-1:0];
    assign bus.ram_ce    = issue;
    assign bus.ram_ad    = pc_reg;
    assign bus.ram_oce   = 1'b1;
    assign bus.ram_wre   = 1'b0;
    assign bus.ram_reset = reset;
endmodule

// File: tb/tb_opram_fetch.sv
// Bench for opram_fetch: RAM model, scoreboard of expected {addr, byte} per accepted opcode,
// plus directed checks for latency, stall, jump, wrap, run/stop and mid-stream reset.
module tb_opram_fetch;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int FDEPTH = 2;

    logic          clk;
    logic          reset;
    logic          run;
    logic          jump_en;
    logic [AW-1:0] jump_addr;

    opram_fetch_if #(.AW(AW), .DW(DW)) bus ();

    opram_fetch #(.AW(AW), .DW(DW), .FDEPTH(FDEPTH), .RESET_PC(8'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    mem [256];
    logic [AW+DW-1:0] exp_q [$];
    int nvec = 0;
    int nmis = 0;
    int npop = 0;
    int outst = 0;

    // Bypass-mode RAM: data for the address issued with ram_ce appears the next cycle.
    always @(posedge clk) begin
        if (bus.ram_ce) bus.ram_dout <= mem[bus.ram_ad];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_start(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, mem[a]});
            a = a + 8'd1;
        end
    endtask

    // Accepted opcodes are compared against the scoreboard; occupancy model bounds the FIFO.
    always @(negedge clk) begin
        if (reset || jump_en) begin
            outst = 0;
        end else begin
            if (bus.op_valid && bus.op_ready) begin
                npop++;
                if (exp_q.size() == 0) begin
                    check("op_unexpected", exp_q.size(), 1);
                end else begin
                    check("op", {bus.op_addr, bus.op_data}, exp_q.pop_front());
                end
            end
            outst = outst + int'(bus.ram_ce) - int'(bus.op_valid && bus.op_ready);
            if (outst > FDEPTH) check("fifo_overflow", outst, FDEPTH);
        end
    end

    int lat;
    int n;
    int p0;
    int nissue;

    initial begin
        logic [7:0] prog [11];
        prog = '{8'h47, 8'h20, 8'h00, 8'h41, 8'h42, 8'h22, 8'h00, 8'h41, 8'h81, 8'h82, 8'h10};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 11; i++) mem[i] = prog[i];

        reset = 1'b1; run = 1'b0; jump_en = 1'b0; jump_addr = '0; bus.op_ready = 1'b0;
        repeat (3) tick();
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_op_data", bus.op_data, 0);
        check("rst_op_addr", bus.op_addr, 0);
        check("rst_ram_ce", bus.ram_ce, 0);
        check("rst_ram_ad", bus.ram_ad, 0);
        check("ram_oce", bus.ram_oce, 1);
        check("ram_wre", bus.ram_wre, 0);
        check("ram_reset_hi", bus.ram_reset, 1);

        // Basic stream from reset
        run = 1'b1; bus.op_ready = 1'b1; sb_start(8'd0, 64); reset = 1'b0;
        lat = 0;
        while (!bus.op_valid && lat < 10) begin tick(); lat++; end
        check("t1_latency", lat, 3);
        check("ram_reset_lo", bus.ram_reset, 0);

        // Jump to 8 while opcode 3 is at the output and addr 4 is returning
        n = 0;
        while (!(bus.op_valid && bus.op_addr == 8'd3) && n < 20) begin tick(); n++; end
        check("t3_at_addr3", {bus.op_valid, bus.op_addr}, {1'b1, 8'd3});
        jump_en = 1'b1; jump_addr = 8'd8; sb_start(8'd8, 64); p0 = npop;
        tick(); jump_en = 1'b0;
        check("t3_gap1", bus.op_valid, 0);
        tick();
        check("t3_gap2", bus.op_valid, 0);
        tick();
        check("t3_first", {bus.op_valid, bus.op_addr, bus.op_data}, {1'b1, 8'd8, 8'h81});
        repeat (4) tick();
        check("t3_progress", (npop - p0) >= 3, 1);

        // Wrap 254 -> 255 -> 0 -> 1
        jump_en = 1'b1; jump_addr = 8'd254; sb_start(8'd254, 64); p0 = npop;
        tick(); jump_en = 1'b0;
        repeat (8) tick();
        check("t4_progress", (npop - p0) >= 4, 1);

        // Stop and resume
        run = 1'b0;
        tick();
        check("t5_ce_off", bus.ram_ce, 0);
        repeat (5) tick();
        check("t5_drained", bus.op_valid, 0);
        check("t5_idle_ce", bus.ram_ce, 0);
        p0 = npop; run = 1'b1;
        repeat (8) tick();
        check("t5_resumed", (npop - p0) >= 4, 1);

        // Stall: only FDEPTH reads may be outstanding, head held
        reset = 1'b1;
        tick();
        check("t2_rst_valid", bus.op_valid, 0);
        bus.op_ready = 1'b0; sb_start(8'd0, 64); reset = 1'b0; nissue = 0;
        repeat (12) begin tick(); nissue += int'(bus.ram_ce); end
        check("t2_issues", nissue, FDEPTH);
        check("t2_hold", {bus.op_valid, bus.op_addr, bus.op_data}, {1'b1, 8'd0, 8'h47});
        p0 = npop; bus.op_ready = 1'b1;
        repeat (10) tick();
        check("t2_progress", (npop - p0) >= 8, 1);

        // Reset while the FIFO holds data and a return is in flight
        check("t6_pre_issue", bus.ram_ce, 1);
        tick();
        reset = 1'b1; sb_start(8'd0, 64);
        tick();
        check("t6_rst_valid", bus.op_valid, 0);
        reset = 1'b0;
        lat = 0;
        while (!bus.op_valid && lat < 10) begin tick(); lat++; end
        check("t6_latency", lat, 3);
        check("t6_first", {bus.op_addr, bus.op_data}, {8'd0, 8'h47});
        p0 = npop;
        repeat (6) tick();
        check("t6_progress", (npop - p0) >= 5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
